// File: rtl/serial_arith_unit.sv
// Bit-serial two's-complement unit: pass / negate / add / subtract, LSB-first,
// one registered result bit per accepted input bit, with word framing and overflow.
module serial_arith_unit #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       valid_in,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       y,
    output logic       valid_out,
    output logic       last_out,
    output logic       ovf
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [1:0] M_PASS = 2'b00, M_NEG = 2'b01, M_ADD = 2'b10, M_SUB = 2'b11;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_idx;
    logic            r_carry, w_carry_nxt;
    logic [1:0]      r_mode, w_mode_nxt, w_mode;
    logic            r_y, r_vld, r_last, r_ovf;
    logic            w_y, w_vld, w_last, w_ovf;
    logic            w_active, w_msb, w_cin, w_c, w_x, w_z, w_sum, w_cout;

    // A start bit always restarts the word, even mid-word; mode[0] doubles as
    // the initial carry (negate and subtract both need +1).
    always_comb begin
        w_active = valid_in & (start | (r_state == RUN));
        w_mode   = start ? mode : r_mode;
        w_idx    = start ? '0 : r_cnt;
        w_cin    = start ? mode[0] : r_carry;
        w_x      = a;
        w_z      = 1'b0;
        w_c      = w_cin;
        case (w_mode)
            M_PASS:  w_c = 1'b0;
            M_NEG:   w_x = ~a;
            M_ADD:   w_z = b;
            M_SUB:   w_z = ~b;
            default: w_c = 1'b0;
        endcase
        w_sum  = w_x ^ w_z ^ w_c;
        w_cout = (w_x & w_z) | (w_x & w_c) | (w_z & w_c);
        w_msb  = w_active && (w_idx == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_mode  <= M_PASS;
            r_y     <= 1'b0;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_carry <= w_carry_nxt;
            r_mode  <= w_mode_nxt;
            r_y     <= w_y;
            r_vld   <= w_vld;
            r_last  <= w_last;
            r_ovf   <= w_ovf;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_carry_nxt = r_carry;
        w_mode_nxt  = r_mode;
        if (w_active) begin
            w_mode_nxt  = w_mode;
            w_carry_nxt = w_cout;
            if (w_msb) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = w_idx + 1'b1;
            end
        end
    end

    // Signed overflow: carry into MSB differs from carry out of MSB.
    always_comb begin
        w_vld  = w_active;
        w_y    = w_active & w_sum;
        w_last = w_msb;
        w_ovf  = w_msb & (w_mode != M_PASS) & (w_c ^ w_cout);
    end

    assign y         = r_y;
    assign valid_out = r_vld;
    assign last_out  = r_last;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed-vector bench for serial_arith_unit at WIDTH=8.
module tb_serial_arith_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, valid_in = 1'b0, a = 1'b0, b = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       y, valid_out, last_out, ovf;
  int         nvec = 0, nmis = 0;

  serial_arith_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .valid_in(valid_in),
    .a(a), .b(b), .mode(mode),
    .y(y), .valid_out(valid_out), .last_out(last_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; return sampled 1 time unit after the edge.
  task automatic step(input logic st, input logic vi, input logic ia, input logic ib,
                      input logic [1:0] md);
    start = st; valid_in = vi; a = ia; b = ib; mode = md;
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input string tag, input logic [1:0] md, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] stall,
                          input logic [7:0] exp_y, input logic exp_ovf);
    logic [7:0] res, lm, om;
    int nv, gv;
    res = '0; lm = '0; om = '0; nv = 0; gv = 0;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 1'b1, av[i], bv[i], md);
      if (valid_out) begin res[i] = y; nv++; end
      lm[i] = last_out;
      om[i] = ovf;
      if (stall[i])
        repeat (2) begin
          step(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
          if (valid_out) gv++;
        end
    end
    chk({tag, ".y"}, res, exp_y);
    chk({tag, ".nvalid"}, nv, 8);
    chk({tag, ".last"}, lm, 8'h80);
    chk({tag, ".ovf"}, om, {exp_ovf, 7'b0});
    if (stall != 0) chk({tag, ".gap"}, gv, 0);
  endtask

  initial begin
    logic [7:0] lm;
    int nv;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.outs", {y, valid_out, last_out, ovf}, 4'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("idle.vld", valid_out, 1'b0);

    // Back-to-back words, no idle cycles between them.
    run_word("neg05",  2'b01, 8'h05, 8'h00, 8'h00, 8'hFB, 1'b0);
    run_word("add7f01",2'b10, 8'h7F, 8'h01, 8'h00, 8'h80, 1'b1);
    run_word("addff01",2'b10, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0);
    run_word("sub0305",2'b11, 8'h03, 8'h05, 8'h00, 8'hFE, 1'b0);
    run_word("neg80",  2'b01, 8'h80, 8'h00, 8'h00, 8'h80, 1'b1);
    run_word("passa5", 2'b00, 8'hA5, 8'hFF, 8'h00, 8'hA5, 1'b0);
    run_word("sub8001",2'b11, 8'h80, 8'h01, 8'h00, 8'h7F, 1'b1);

    // Stalls after bits 2 and 5.
    run_word("negstall", 2'b01, 8'h05, 8'h00, 8'h24, 8'hFB, 1'b0);

    // Abort a negate word at bit 4 with a new add word.
    lm = '0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01); lm[0] = last_out | ovf;
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10); lm[1] = last_out | ovf;
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10); lm[2] = last_out | ovf;
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10); lm[3] = last_out | ovf;
    chk("abort.nolast", lm, 8'h00);
    run_word("abort.add1223", 2'b10, 8'h12, 8'h23, 8'h00, 8'h35, 1'b0);

    // Reset mid-word: add with a=b=1 on bits 0..2 makes y=1 on bit 2.
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    chk("prerst.outs", {y, valid_out}, 2'b11);
    reset = 1'b1;
    #2;
    chk("midrst.outs", {y, valid_out, last_out, ovf}, 4'b0);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
      if (valid_out) nv++;
    end
    chk("postrst.ignored", nv, 0);
    run_word("postrst.add4040", 2'b10, 8'h40, 8'h40, 8'h00, 8'h80, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("end.idle", {valid_out, last_out}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
